// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier-accumulator.
package mult_pkg;

  localparam int MULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/binary_multiplier_seq.sv
// Shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit per clock; also reconstructs divider results (q*d + r).
module binary_multiplier_seq
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   addend,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          state, nextState;
  logic [2*W-1:0]  acc, mcand, accSum;
  logic [W-1:0]    mplr;
  logic [CW-1:0]   cnt;
  logic            load, lastStep;

  // A new operation can only be loaded when no operation is running.
  assign load     = start && (state != RUN);
  assign lastStep = (state == RUN) && (cnt == LAST);
  assign accSum   = mplr[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (cnt == LAST) nextState = DONE;
      DONE:    nextState = start ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; reset aborts without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (nextState == RUN);
      done <= (nextState == DONE);
      if (load) begin
        acc   <= {{W{1'b0}}, addend};
        mcand <= {{W{1'b0}}, multiplicand};
        mplr  <= multiplier;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= accSum;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        cnt   <= cnt + 1'b1;
        if (lastStep) product <= accSum;
      end
    end
  end

endmodule

// File: doc/binary_multiplier_seq.md
Name: binary_multiplier_seq

Overview:
- Sequential shift-add multiplier-accumulator: product = multiplicand * multiplier + addend.
- It is the inverse of binary_divider. Feeding it quotient, divisor and remainder must reproduce the dividend, so it doubles as a reconstruction checker for divider results.
- It sits beside binary_divider on a single clock domain and is driven by a start/busy/done handshake.

Parameters:
- W, 8, operand width in bits. Product width is 2*W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on the rising edge of clk.
- multiplicand  input  W  operand A; the divider's quotient in checker use.
- multiplier  input  W  operand B; the divider's divisor in checker use.
- addend  input  W  value added to A*B; the divider's remainder in checker use.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*W  A*B + addend; held until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- States: IDLE, RUN, DONE (encoded 2 bits).
- Accept rule:
  - start is accepted at an edge where busy=0, i.e. in state IDLE or DONE.
  - start while busy=1 is ignored; there is no queueing.
- Load at accept edge k:
  - acc <= {W zeros, addend}.
  - mcand <= zero-extended multiplicand (2*W).
  - mplr <= multiplier.
  - cnt <= 0.
  - state <= RUN.
- RUN, edges k+1 .. k+W, one bit per edge:
  - if mplr[0], acc <= acc + mcand (2*W-bit add, no carry out).
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt + 1.
  - At the edge where cnt == W-1: product <= final acc, state <= DONE.
- DONE, one cycle:
  - done=1, busy=0.
  - Next edge: to RUN if start (new load), else to IDLE.
- busy: registered, high for exactly W cycles (after edge k through edge k+W).
- done: registered, high for exactly one cycle (after edge k+W).
- Latency: result is visible W clock edges after the accept edge.
- Back-to-back: start held high continuously gives one result every W+1 cycles.
- Width: the maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so no overflow can occur; no saturation logic.
- Zero operands: multiplier=0 or multiplicand=0 still takes the full W cycles; product=addend.
- Operand capture: inputs are captured at accept only. Later input changes do not affect the running operation.
- product stability: product changes only at completion edges and on reset.
- Reset mid-operation:
  - Takes priority over start and over RUN progress.
  - Aborts the operation with no done pulse; product returns to 0.
- Simultaneous rst and start: rst wins; start is not accepted.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - default width constant MULT_W=8.
- Counter width: $clog2(W) bits, declared locally.
- No sub-module: the datapath is a single adder plus shifters and stays in one module.

Test Plan:
- Reset then start with A=5, B=3, add=0 -> busy for 8 cycles, done pulse, product=15 (16'h000F).
- Divider-reconstruction sequence (A,B,add) = (5,5,3), (20,5,0), (20,6,3) -> product = 28, 100, 123 respectively; each done exactly 8 cycles after its accept.
- Corner cases A=255, B=255, add=255 and A=0, B=200, add=7 -> product=65280 (16'hFF00) and 7 respectively; full latency both times.
- start pulsed at cycle 3 of a running 5*3 op, with different operands on the inputs -> ignored; product=15; no extra done.
- start held high continuously with A=2, B=3, add=1 -> product=7 with done every 9 cycles; busy low only in the DONE cycles.
- rst asserted at cycle 4 of a 255*255 op -> next cycle busy=0, done=0, product=0; no done pulse follows; a following 5*3 op gives 15.
